// File: rtl/controle_contexto_if.sv
// controle_contexto_if
//   Groups the core-facing signals of the program-counter / process-context
//   unit. Clock and reset are kept outside as plain module ports.
//   Signals:
//     InputPC             core -> ctx  next PC, already branch/jump resolved
//     Halt                core -> ctx  freeze PC, quantum counter and requests
//     TrocaReq            core -> ctx  one-cycle switch request
//     PID_CPU             core -> ctx  target PID for TrocaReq
//     PreemptEn           core -> ctx  enables quantum preemption
//     Endereco            ctx -> core  current process-relative PC
//     DeslocamentoMemoria ctx -> core  memory base of the running process
//     PID_Atual           ctx -> core  running PID (0 = kernel)
//     Stall               ctx -> core  switch in progress, do not commit
//   Modports: master = core side, slave = context unit.
interface controle_contexto_if;
  logic [31:0] InputPC;
  logic        Halt;
  logic        TrocaReq;
  logic [4:0]  PID_CPU;
  logic        PreemptEn;
  logic [31:0] Endereco;
  logic [31:0] DeslocamentoMemoria;
  logic [4:0]  PID_Atual;
  logic        Stall;

  modport master (
    output InputPC, Halt, TrocaReq, PID_CPU, PreemptEn,
    input  Endereco, DeslocamentoMemoria, PID_Atual, Stall
  );

  modport slave (
    input  InputPC, Halt, TrocaReq, PID_CPU, PreemptEn,
    output Endereco, DeslocamentoMemoria, PID_Atual, Stall
  );
endinterface

// File: rtl/controle_contexto.sv
// controle_contexto
//   Program counter and process context unit feeding the single-cycle core.
//   Holds the PC of the running process, a saved-PC table per PID, and
//   performs two-cycle context switches (SAVE then LOAD) on a syscall
//   request or on quantum expiry of a user process.
//   Ports:
//     Clock  rising-edge clock
//     Reset  asynchronous active-high reset, clears all state and the table
//     bus    controle_contexto_if.slave (see interface file for signals)
module controle_contexto #(
  parameter int unsigned QUANTUM   = 64,
  parameter int unsigned PAGE_LOG2 = 10,
  parameter int unsigned NUM_PROC  = 32
) (
  input logic                 Clock,
  input logic                 Reset,
  controle_contexto_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(QUANTUM) + 1;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    SAVE = 2'd1,
    LOAD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      ret_q, ret_d;
  logic [4:0]       pid_q, pid_d;
  logic [4:0]       target_q, target_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      tabela_q [NUM_PROC];
  logic [31:0]      tabela_d [NUM_PROC];

  logic user_preempt;
  logic expiry;

  assign user_preempt = (pid_q != '0) && bus.PreemptEn;
  // Compare against the pre-increment value: the QUANTUM-th committed cycle
  // of the process is the one that triggers the switch.
  assign expiry       = user_preempt && (cnt_q == CNT_W'(QUANTUM - 1));

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ret_d    = ret_q;
    pid_d    = pid_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    tabela_d = tabela_q;

    case (state_q)
      RUN: begin
        if (!bus.Halt) begin
          if (user_preempt) cnt_d = cnt_q + CNT_W'(1);
          if (bus.TrocaReq) begin
            // Syscall wins over expiry; PC stays so the core sees no commit.
            target_d = bus.PID_CPU;
            ret_d    = bus.InputPC;
            state_d  = SAVE;
          end else begin
            pc_d = bus.InputPC;
            if (expiry) begin
              target_d = '0;
              ret_d    = bus.InputPC;
              state_d  = SAVE;
            end
          end
        end
      end
      SAVE: begin
        tabela_d[pid_q] = ret_q;
        state_d         = LOAD;
      end
      LOAD: begin
        // Table written in SAVE is visible here, so a same-PID switch
        // resumes at the latched return address.
        pid_d   = target_q;
        pc_d    = tabela_q[target_q];
        cnt_d   = '0;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= RUN;
      pc_q     <= '0;
      ret_q    <= '0;
      pid_q    <= '0;
      target_q <= '0;
      cnt_q    <= '0;
      for (int unsigned i = 0; i < NUM_PROC; i++) tabela_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ret_q    <= ret_d;
      pid_q    <= pid_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      tabela_q <= tabela_d;
    end
  end

  assign bus.Endereco            = pc_q;
  assign bus.PID_Atual           = pid_q;
  assign bus.DeslocamentoMemoria = 32'(pid_q) << PAGE_LOG2;
  assign bus.Stall               = (state_q != RUN);

endmodule
